// File: rtl/map_memory_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pacman_map_pkg
// Description : Shared definitions for the Pacman tile-map store: default map
//               geometry, tile codes, controller state encoding and the
//               (x, y) -> linear address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pacman_map_pkg;

  localparam int DEF_MAP_W  = 21;
  localparam int DEF_MAP_H  = 21;
  localparam int DEF_DATA_W = 3;

  typedef enum logic [2:0] {
    TILE_EMPTY  = 3'd0,
    TILE_WALL   = 3'd1,
    TILE_PELLET = 3'd2,
    TILE_PACMAN = 3'd3,
    TILE_GHOST  = 3'd4
  } tile_e;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } map_state_e;

  // Row-major linear address. Callers narrow the result only after checking
  // the coordinates are in range, so the narrowing never loses bits.
  function automatic int unsigned coord_to_addr(input int unsigned x,
                                                input int unsigned y,
                                                input int unsigned map_w);
    return y * map_w + x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/map_memory_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : map_memory_controller_if
// Description : Game-port and video-port signal bundle of the map controller.
//               master : game logic / renderer side (drives requests, coords)
//               slave  : the map controller
//   map_x/map_y/readwrite/req/sprite_data_in -> controller
//   sprite_data_out/ack/oob/busy             <- controller
//   vga_x/vga_y -> controller, vga_data_out  <- controller
// Revision    : 1.0 - initial release
// ============================================================================
interface map_memory_controller_if #(
  parameter int X_W    = 5,
  parameter int Y_W    = 5,
  parameter int DATA_W = 3
);
  logic [X_W-1:0]    map_x;
  logic [Y_W-1:0]    map_y;
  logic              readwrite;
  logic              req;
  logic [DATA_W-1:0] sprite_data_in;
  logic [DATA_W-1:0] sprite_data_out;
  logic              ack;
  logic              oob;
  logic              busy;
  logic [X_W-1:0]    vga_x;
  logic [Y_W-1:0]    vga_y;
  logic [DATA_W-1:0] vga_data_out;

  modport master (
    output map_x, map_y, readwrite, req, sprite_data_in, vga_x, vga_y,
    input  sprite_data_out, ack, oob, busy, vga_data_out
  );

  modport slave (
    input  map_x, map_y, readwrite, req, sprite_data_in, vga_x, vga_y,
    output sprite_data_out, ack, oob, busy, vga_data_out
  );
endinterface
`default_nettype wire

// File: rtl/map_memory_controller_ram_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : map_ram_2r1w
// Description : Simple dual-port RAM, one synchronous write port and two
//               registered read ports. Reads return the pre-write contents
//               on a same-address collision (read-before-write).
//   clk                       clock
//   we / waddr / wdata        write port
//   re_a / raddr_a / rdata_a  read port A (holds when re_a = 0)
//   raddr_b / rdata_b         read port B (reads every cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module map_ram_2r1w #(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 441,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic              re_a,
  input  wire logic [ADDR_W-1:0] raddr_a,
  output logic      [DATA_W-1:0] rdata_a,
  input  wire logic [ADDR_W-1:0] raddr_b,
  output logic      [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re_a) begin
      rdata_a <= mem[raddr_a];
    end
    rdata_b <= mem[raddr_b];
  end

endmodule
`default_nettype wire

// File: rtl/map_memory_controller.sv
`default_nettype none
// ============================================================================
// Module      : map_memory_controller
// Description : MAP_W x MAP_H tile-map store. After reset an init sweep writes
//               the default maze (walls on the border, pellets inside), one
//               cell per cycle. Then the game port serves handshaked single
//               cell reads/writes and the video port streams reads.
//   clock_50 : system clock, posedge
//   reset_n  : synchronous reset, ACTIVE-HIGH despite its name
//   bus      : game port (map_x, map_y, readwrite, req, sprite_data_in ->
//              sprite_data_out, ack, oob, busy) and video port
//              (vga_x, vga_y -> vga_data_out)
// Revision    : 1.0 - initial release
// ============================================================================
module map_memory_controller
  import pacman_map_pkg::*;
#(
  parameter int                MAP_W       = DEF_MAP_W,
  parameter int                MAP_H       = DEF_MAP_H,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                X_W         = 5,
  parameter int                Y_W         = 5,
  parameter logic [DATA_W-1:0] BORDER_TILE = DATA_W'(TILE_WALL),
  parameter logic [DATA_W-1:0] FILL_TILE   = DATA_W'(TILE_PELLET)
) (
  input wire logic              clock_50,
  input wire logic              reset_n,
  map_memory_controller_if.slave bus
);

  localparam int                DEPTH     = MAP_W * MAP_H;
  localparam int                ADDR_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(MAP_W - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(MAP_H - 1);
  // One extra bit so MAP_W == 2**X_W still compares correctly.
  localparam logic [X_W:0]      X_LIMIT   = (X_W + 1)'(MAP_W);
  localparam logic [Y_W:0]      Y_LIMIT   = (Y_W + 1)'(MAP_H);

  map_state_e        state, next_state;
  logic [ADDR_W-1:0] init_addr;
  logic [X_W-1:0]    init_x;
  logic [Y_W-1:0]    init_y;
  logic [DATA_W-1:0] init_tile;

  logic              game_in_range, vga_in_range;
  logic [ADDR_W-1:0] game_addr, vga_addr;
  logic              accept, game_rd;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q_game, ram_q_vga;

  logic              ack_q, oob_q;
  // Force-zero flags: let registered outputs read 0 after reset, out-of-range
  // reads and the init sweep without needing a reset on the RAM itself.
  logic              rd_zero, vga_zero;

  assign game_in_range = ({1'b0, bus.map_x} < X_LIMIT) && ({1'b0, bus.map_y} < Y_LIMIT);
  assign vga_in_range  = ({1'b0, bus.vga_x} < X_LIMIT) && ({1'b0, bus.vga_y} < Y_LIMIT);

  // Out-of-range coordinates are steered to address 0 so the RAM is never
  // indexed past DEPTH; their results are masked by the flags above.
  assign game_addr = game_in_range ?
      ADDR_W'(coord_to_addr(32'(bus.map_x), 32'(bus.map_y), MAP_W)) : '0;
  assign vga_addr  = vga_in_range ?
      ADDR_W'(coord_to_addr(32'(bus.vga_x), 32'(bus.vga_y), MAP_W)) : '0;

  assign init_tile = ((init_x == '0) || (init_x == X_LAST) ||
                      (init_y == '0) || (init_y == Y_LAST)) ? BORDER_TILE : FILL_TILE;

  assign game_rd = accept && !bus.readwrite && game_in_range;

  always_ff @(posedge clock_50) begin
    if (reset_n) begin
      state <= ST_INIT;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus the write-port mux shared by the sweep and the game port.
  always_comb begin
    next_state = state;
    ram_we     = 1'b0;
    ram_waddr  = init_addr;
    ram_wdata  = init_tile;
    accept     = 1'b0;
    case (state)
      ST_INIT: begin
        ram_we = 1'b1;
        if (init_addr == LAST_ADDR) begin
          next_state = ST_IDLE;
        end
      end
      ST_IDLE: begin
        accept = bus.req;
        if (bus.req && bus.readwrite && game_in_range) begin
          ram_we    = 1'b1;
          ram_waddr = game_addr;
          ram_wdata = bus.sprite_data_in;
        end
      end
      default: next_state = ST_INIT;
    endcase
    // Nothing is written or accepted on a reset edge; the sweep that follows
    // rebuilds every cell anyway.
    if (reset_n) begin
      ram_we = 1'b0;
      accept = 1'b0;
    end
  end

  always_ff @(posedge clock_50) begin
    if (reset_n) begin
      init_addr <= '0;
      init_x    <= '0;
      init_y    <= '0;
      ack_q     <= 1'b0;
      oob_q     <= 1'b0;
      rd_zero   <= 1'b1;
      vga_zero  <= 1'b1;
    end else begin
      if (state == ST_INIT) begin
        init_addr <= init_addr + ADDR_W'(1);
        if (init_x == X_LAST) begin
          init_x <= '0;
          init_y <= init_y + Y_W'(1);
        end else begin
          init_x <= init_x + X_W'(1);
        end
      end
      ack_q <= accept;
      oob_q <= accept && !game_in_range;
      // Only reads touch the read-data view; writes leave it holding.
      if (accept && !bus.readwrite) begin
        rd_zero <= !game_in_range;
      end
      vga_zero <= (state != ST_IDLE) || !vga_in_range;
    end
  end

  map_ram_2r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clock_50),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .re_a    (game_rd),
    .raddr_a (game_addr),
    .rdata_a (ram_q_game),
    .raddr_b (vga_addr),
    .rdata_b (ram_q_vga)
  );

  assign bus.sprite_data_out = rd_zero  ? '0 : ram_q_game;
  assign bus.vga_data_out    = vga_zero ? '0 : ram_q_vga;
  assign bus.ack             = ack_q;
  assign bus.oob             = oob_q;
  assign bus.busy            = (state == ST_INIT);

endmodule
`default_nettype wire

// File: tb/tb_map_memory_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_map_memory_controller
// Description : Self-checking bench for map_memory_controller. A cell-array
//               model predicts every output each cycle; directed sequences
//               pin the model with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_map_memory_controller;

  localparam int W = 21;
  localparam int H = 21;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  map_memory_controller_if #(.X_W(5), .Y_W(5), .DATA_W(3)) bus ();

  map_memory_controller dut (
    .clock_50 (clk),
    .reset_n  (rst),
    .bus      (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int def_tile(input int a);
    int x;
    int y;
    x = a % W;
    y = a / W;
    return (x == 0 || x == W - 1 || y == 0 || y == H - 1) ? 1 : 2;
  endfunction

  // ---------------- behavioural model ----------------
  int          mem_m[N];
  int          sweep_left = 0;
  logic [31:0] exp_busy, exp_ack, exp_oob, exp_rd, exp_vga;
  bit          chk_on = 1'b0;

  always @(posedge clk) begin : model
    int  gx, gy, vx, vy;
    bit  inr;
    gx = int'(bus.map_x);
    gy = int'(bus.map_y);
    vx = int'(bus.vga_x);
    vy = int'(bus.vga_y);
    if (rst) begin
      sweep_left = N;
      exp_busy = 1; exp_ack = 0; exp_oob = 0; exp_rd = 0; exp_vga = 0;
    end else if (sweep_left > 0) begin
      sweep_left--;
      if (sweep_left == 0) begin
        for (int a = 0; a < N; a++) mem_m[a] = def_tile(a);
      end
      exp_busy = (sweep_left > 0) ? 1 : 0;
      exp_ack = 0; exp_oob = 0; exp_vga = 0;
    end else begin
      exp_busy = 0;
      exp_vga = (vx < W && vy < H) ? mem_m[vy * W + vx] : 0;
      exp_ack = {31'd0, bus.req};
      exp_oob = 0;
      if (bus.req) begin
        inr = (gx < W && gy < H);
        exp_oob = inr ? 0 : 1;
        if (!bus.readwrite) exp_rd = inr ? mem_m[gy * W + gx] : 0;
        else if (inr) mem_m[gy * W + gx] = int'(bus.sprite_data_in);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", {31'd0, bus.busy}, exp_busy);
      check("ack", {31'd0, bus.ack}, exp_ack);
      check("oob", {31'd0, bus.oob}, exp_oob);
      check("rd_data", {29'd0, bus.sprite_data_out}, exp_rd);
      check("vga_data", {29'd0, bus.vga_data_out}, exp_vga);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_req(input bit rw, input int x, input int y, input int d);
    bus.req            = 1'b1;
    bus.readwrite      = rw;
    bus.map_x          = 5'(x);
    bus.map_y          = 5'(y);
    bus.sprite_data_in = 3'(d);
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic rd_pin(input string name, input int x, input int y, input int exp);
    do_req(1'b0, x, y, 0);
    check(name, {29'd0, bus.sprite_data_out}, exp);
  endtask

  task automatic wait_sweep(input string name);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, bus.busy}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.req = 1'b0; bus.readwrite = 1'b0; bus.map_x = '0; bus.map_y = '0;
    bus.sprite_data_in = '0; bus.vga_x = '0; bus.vga_y = '0;
    @(negedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    check("reset_busy", {31'd0, bus.busy}, 1);
    check("reset_ack", {31'd0, bus.ack}, 0);
    rst = 1'b0;

    // Sweep with req held high; a write to (10,10) lands at sweep cycle 100.
    n = 0;
    while (bus.busy === 1'b1 && n < 1000) begin
      bus.req            = 1'b1;
      bus.readwrite      = (n == 100);
      bus.map_x          = 5'd10;
      bus.map_y          = 5'd10;
      bus.sprite_data_in = 3'd7;
      check("ack_in_init", {31'd0, bus.ack}, 0);
      @(negedge clk);
      n++;
    end
    bus.req = 1'b0;
    check("busy_cycles", n, 441);

    rd_pin("pin_0_0", 0, 0, 1);
    check("pin_ack", {31'd0, bus.ack}, 1);
    rd_pin("pin_20_5", 20, 5, 1);
    rd_pin("pin_7_20", 7, 20, 1);
    rd_pin("pin_1_1", 1, 1, 2);
    rd_pin("pin_10_10", 10, 10, 2);

    // Write then read back-to-back.
    do_req(1'b1, 3, 4, 5);
    check("wr_ack", {31'd0, bus.ack}, 1);
    rd_pin("rd_3_4", 3, 4, 5);
    check("rd_ack", {31'd0, bus.ack}, 1);
    rd_pin("rd_2_4", 2, 4, 2);
    rd_pin("rd_4_4", 4, 4, 2);

    // Out-of-range accesses.
    do_req(1'b1, 21, 0, 7);
    check("oob_wr_ack", {31'd0, bus.ack}, 1);
    check("oob_wr_oob", {31'd0, bus.oob}, 1);
    check("oob_wr_hold", {29'd0, bus.sprite_data_out}, 2);
    rd_pin("oob_rd_data", 0, 21, 0);
    check("oob_rd_oob", {31'd0, bus.oob}, 1);
    rd_pin("cell0_intact", 0, 0, 1);
    check("inr_oob", {31'd0, bus.oob}, 0);

    // Collision: video sees old data this cycle, new data next.
    bus.vga_x = 5'd5; bus.vga_y = 5'd5;
    do_req(1'b1, 5, 5, 4);
    check("coll_old", {29'd0, bus.vga_data_out}, 2);
    @(negedge clk);
    check("coll_new", {29'd0, bus.vga_data_out}, 4);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.req            = ($urandom_range(0, 3) != 0);
      bus.readwrite      = $urandom_range(0, 1) == 1;
      bus.map_x          = 5'($urandom_range(0, 23));
      bus.map_y          = 5'($urandom_range(0, 23));
      bus.sprite_data_in = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        bus.vga_x = bus.map_x;
        bus.vga_y = bus.map_y;
      end else begin
        bus.vga_x = 5'($urandom_range(0, 23));
        bus.vga_y = 5'($urandom_range(0, 23));
      end
      @(negedge clk);
    end
    bus.req = 1'b0;

    // Reset, then reset again 200 cycles into the sweep.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_sweep("resweep_done");

    for (int a = 0; a < N; a++) begin
      bus.vga_x = 5'(a % W);
      bus.vga_y = 5'(a / W);
      @(negedge clk);
      check("vga_scan", {29'd0, bus.vga_data_out}, def_tile(a));
    end
    rd_pin("after_3_4", 3, 4, 2);
    rd_pin("after_5_5", 5, 5, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
